// File: rtl/des_job_injector_pkg.sv
// Shared constants and types for the DES mesh job injector.
// Holds the channel width, the header field map, the packet lengths,
// the job payload struct, both FSM state enums and a header builder.
package des_job_injector_pkg;

    localparam int unsigned CHANNEL_WIDTH = 32;
    localparam int unsigned ADDR_FIELD    = 4;

    // Header layout: flag at the MSB, then dest X/Y and src X/Y nibbles at the bottom
    localparam int unsigned HEADER_FLAG   = 31;
    localparam int unsigned DEST_X_LSB    = 12;
    localparam int unsigned DEST_Y_LSB    = 8;
    localparam int unsigned SRC_X_LSB     = 4;
    localparam int unsigned SRC_Y_LSB     = 0;

    localparam int unsigned JOB_FLITS     = 5;
    localparam int unsigned RESULT_FLITS  = 3;
    localparam int unsigned FLIT_IDX_W    = 3;

    typedef logic [CHANNEL_WIDTH-1:0]   flit_t;
    typedef logic [2*CHANNEL_WIDTH-1:0] block_t;
    typedef logic [ADDR_FIELD-1:0]      addr_t;

    typedef struct packed {
        addr_t  dest_x;
        addr_t  dest_y;
        block_t plaintext;
        block_t key;
    } job_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HI   = 2'd1,
        RX_LO   = 2'd2
    } rx_state_e;

    // Build a header flit from destination and source coordinates
    function automatic flit_t make_header(addr_t dx, addr_t dy, addr_t sx, addr_t sy);
        flit_t h;
        h = '0;
        h[HEADER_FLAG]                 = 1'b1;
        h[DEST_X_LSB +: ADDR_FIELD]    = dx;
        h[DEST_Y_LSB +: ADDR_FIELD]    = dy;
        h[SRC_X_LSB  +: ADDR_FIELD]    = sx;
        h[SRC_Y_LSB  +: ADDR_FIELD]    = sy;
        return h;
    endfunction

endpackage

// File: rtl/des_job_injector_if.sv
// Host job handshake, router channel and result bus of the job injector.
// master: host/router side (drives jobs, credits and incoming flits).
// slave : the injector (drives ready, outgoing flits, credits and results).
interface des_job_injector_if;
    import des_job_injector_pkg::*;

    logic   job_valid_din;
    logic   job_ready_dout;
    addr_t  dest_x_din;
    addr_t  dest_y_din;
    block_t plaintext_din;
    block_t key_din;

    flit_t  channel_dout;
    logic   credit_in_din;
    flit_t  channel_din;
    logic   credit_out_dout;

    logic   result_valid_dout;
    block_t ciphertext_dout;
    addr_t  result_src_x_dout;
    addr_t  result_src_y_dout;

    modport master (
        output job_valid_din, dest_x_din, dest_y_din, plaintext_din, key_din,
        output credit_in_din, channel_din,
        input  job_ready_dout, channel_dout, credit_out_dout,
        input  result_valid_dout, ciphertext_dout, result_src_x_dout, result_src_y_dout
    );

    modport slave (
        input  job_valid_din, dest_x_din, dest_y_din, plaintext_din, key_din,
        input  credit_in_din, channel_din,
        output job_ready_dout, channel_dout, credit_out_dout,
        output result_valid_dout, ciphertext_dout, result_src_x_dout, result_src_y_dout
    );

endinterface

// File: rtl/des_job_injector_credit_counter.sv
// Saturating credit counter for a credit-flow-controlled router channel.
// Ports: clk, reset (async, active-high); inc = credit returned, dec = flit sent;
// ok_to_start_c = enough credits (counting this cycle's return) for a whole packet.
module credit_counter #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned NEED  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic ok_to_start_c
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [SUM_W-1:0] avail_c;
    logic [SUM_W-1:0] sum_c;

    // Next count: add the returned credit, remove the sent flit, clip at DEPTH
    always_comb begin
        avail_c = SUM_W'(count_q) + SUM_W'(inc);
        sum_c   = avail_c - SUM_W'(dec);
        count_d = (sum_c > SUM_W'(DEPTH)) ? CNT_W'(DEPTH) : sum_c[CNT_W-1:0];
    end

    // A credit arriving this cycle already frees a slot for the flit sent at this edge
    assign ok_to_start_c = (avail_c >= SUM_W'(NEED));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= CNT_W'(DEPTH);
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/des_job_injector.sv
// Host-side DES mesh injector: sends 5-flit job packets over a credit-flow
// channel and collects 3-flit result packets for the host.
// Ports: clk, reset (async, active-high), bus (slave modport): job handshake
// and fields, outgoing channel with credit input, incoming channel with
// credit output, result strobe with ciphertext and producing node.
module des_job_injector
    import des_job_injector_pkg::*;
#(
    parameter int unsigned X_LOCAL      = 0,
    parameter int unsigned Y_LOCAL      = 0,
    parameter int unsigned BUFFER_DEPTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    des_job_injector_if.slave  bus
);

    localparam addr_t                 SRC_X    = ADDR_FIELD'(X_LOCAL);
    localparam addr_t                 SRC_Y    = ADDR_FIELD'(Y_LOCAL);
    localparam logic [FLIT_IDX_W-1:0] LAST_IDX = FLIT_IDX_W'(JOB_FLITS - 1);

    tx_state_e              tx_state_q, tx_state_d;
    logic [FLIT_IDX_W-1:0]  tx_idx_q, tx_idx_d;
    job_t                   job_q, job_d;
    logic                   job_ready_q, job_ready_d;
    flit_t                  channel_q, channel_d;
    logic                   flit_sent_c;
    logic                   ok_to_start_c;

    rx_state_e              rx_state_q, rx_state_d;
    addr_t                  rx_src_x_q, rx_src_x_d;
    addr_t                  rx_src_y_q, rx_src_y_d;
    flit_t                  ct_hi_q, ct_hi_d;
    logic                   credit_out_q, credit_out_d;
    logic                   result_valid_q, result_valid_d;
    block_t                 ciphertext_q, ciphertext_d;
    addr_t                  res_src_x_q, res_src_x_d;
    addr_t                  res_src_y_q, res_src_y_d;

    credit_counter #(
        .DEPTH (BUFFER_DEPTH),
        .NEED  (JOB_FLITS)
    ) u_credit_counter (
        .clk           (clk),
        .reset         (reset),
        .inc           (bus.credit_in_din),
        .dec           (flit_sent_c),
        .ok_to_start_c (ok_to_start_c)
    );

    // Transmit: latch a job, wait for a full packet of credits, then stream 5 flits
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_idx_d    = tx_idx_q;
        job_d       = job_q;
        job_ready_d = job_ready_q;
        channel_d   = '0;
        flit_sent_c = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                job_ready_d = 1'b1;
                if (bus.job_valid_din && job_ready_q) begin
                    job_d = '{dest_x:    bus.dest_x_din,
                              dest_y:    bus.dest_y_din,
                              plaintext: bus.plaintext_din,
                              key:       bus.key_din};
                    job_ready_d = 1'b0;
                    tx_state_d  = TX_SEND;
                    tx_idx_d    = '0;
                    // Header can leave on the accepting edge so it shows in the next cycle
                    if (ok_to_start_c) begin
                        channel_d   = make_header(job_d.dest_x, job_d.dest_y, SRC_X, SRC_Y);
                        flit_sent_c = 1'b1;
                        tx_idx_d    = FLIT_IDX_W'(1);
                    end
                end
            end
            TX_SEND: begin
                job_ready_d = 1'b0;
                flit_sent_c = 1'b1;
                tx_idx_d    = tx_idx_q + FLIT_IDX_W'(1);
                case (tx_idx_q)
                    FLIT_IDX_W'(0): begin
                        if (ok_to_start_c) begin
                            channel_d = make_header(job_q.dest_x, job_q.dest_y, SRC_X, SRC_Y);
                        end else begin
                            flit_sent_c = 1'b0;
                            tx_idx_d    = tx_idx_q;
                        end
                    end
                    FLIT_IDX_W'(1): channel_d = job_q.plaintext[CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    FLIT_IDX_W'(2): channel_d = job_q.plaintext[0 +: CHANNEL_WIDTH];
                    FLIT_IDX_W'(3): channel_d = job_q.key[CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    default: begin
                        channel_d = job_q.key[0 +: CHANNEL_WIDTH];
                        if (tx_idx_q >= LAST_IDX) begin
                            tx_state_d  = TX_IDLE;
                            tx_idx_d    = '0;
                            job_ready_d = 1'b1;
                        end
                    end
                endcase
            end
            default: begin
                tx_state_d  = TX_IDLE;
                job_ready_d = 1'b1;
            end
        endcase
    end

    // Receive: header -> ciphertext hi -> ciphertext lo; every consumed flit returns a credit
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_src_x_d     = rx_src_x_q;
        rx_src_y_d     = rx_src_y_q;
        ct_hi_d        = ct_hi_q;
        credit_out_d   = 1'b0;
        result_valid_d = 1'b0;
        ciphertext_d   = ciphertext_q;
        res_src_x_d    = res_src_x_q;
        res_src_y_d    = res_src_y_q;
        case (rx_state_q)
            RX_IDLE: begin
                // Stray non-header flits are still consumed so the router gets its slot back
                if (bus.channel_din != '0) begin
                    credit_out_d = 1'b1;
                    if (bus.channel_din[HEADER_FLAG]) begin
                        rx_src_x_d = bus.channel_din[SRC_X_LSB +: ADDR_FIELD];
                        rx_src_y_d = bus.channel_din[SRC_Y_LSB +: ADDR_FIELD];
                        rx_state_d = RX_HI;
                    end
                end
            end
            RX_HI: begin
                // Body flits follow the header back-to-back, so a zero word is still data
                credit_out_d = 1'b1;
                ct_hi_d      = bus.channel_din;
                rx_state_d   = RX_LO;
            end
            RX_LO: begin
                credit_out_d   = 1'b1;
                ciphertext_d   = {ct_hi_q, bus.channel_din};
                res_src_x_d    = rx_src_x_q;
                res_src_y_d    = rx_src_y_q;
                result_valid_d = 1'b1;
                rx_state_d     = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q     <= TX_IDLE;
            tx_idx_q       <= '0;
            job_q          <= '0;
            job_ready_q    <= 1'b1;
            channel_q      <= '0;
            rx_state_q     <= RX_IDLE;
            rx_src_x_q     <= '0;
            rx_src_y_q     <= '0;
            ct_hi_q        <= '0;
            credit_out_q   <= 1'b0;
            result_valid_q <= 1'b0;
            ciphertext_q   <= '0;
            res_src_x_q    <= '0;
            res_src_y_q    <= '0;
        end else begin
            tx_state_q     <= tx_state_d;
            tx_idx_q       <= tx_idx_d;
            job_q          <= job_d;
            job_ready_q    <= job_ready_d;
            channel_q      <= channel_d;
            rx_state_q     <= rx_state_d;
            rx_src_x_q     <= rx_src_x_d;
            rx_src_y_q     <= rx_src_y_d;
            ct_hi_q        <= ct_hi_d;
            credit_out_q   <= credit_out_d;
            result_valid_q <= result_valid_d;
            ciphertext_q   <= ciphertext_d;
            res_src_x_q    <= res_src_x_d;
            res_src_y_q    <= res_src_y_d;
        end
    end

    assign bus.job_ready_dout    = job_ready_q;
    assign bus.channel_dout      = channel_q;
    assign bus.credit_out_dout   = credit_out_q;
    assign bus.result_valid_dout = result_valid_q;
    assign bus.ciphertext_dout   = ciphertext_q;
    assign bus.result_src_x_dout = res_src_x_q;
    assign bus.result_src_y_dout = res_src_y_q;

endmodule

// File: tb/tb_des_job_injector.sv
// Bench for des_job_injector: directed scenarios plus a randomized full-duplex
// run, all checked every cycle against a packet-level reference model
// (queue of pending job flits, integer credit count, planned result packets).
module tb_des_job_injector;

    localparam int DEPTH = 5;
    localparam int NEED  = 5;

    typedef struct {
        logic [31:0] flit;
        bit          body;
        bit          last;
        logic [63:0] ct;
        int          sx;
        int          sy;
    } rx_item_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    des_job_injector_if bus ();

    des_job_injector #(
        .X_LOCAL      (0),
        .Y_LOCAL      (0),
        .BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] tx_q[$];
    bit          tx_started;
    int          credits;
    bit          m_ready, m_acc, m_cred_out, m_valid;
    logic [31:0] m_chan;
    logic [63:0] m_ct;
    int          m_sx, m_sy;
    rx_item_t    rx_q[$];

    logic [31:0] basic_exp [5];
    logic [63:0] pt, key, ct;

    function automatic logic [31:0] hdr(int dx, int dy, int sx, int sy);
        return 32'h8000_0000 | (32'(dx) << 12) | (32'(dy) << 8) | (32'(sx) << 4) | 32'(sy);
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        tx_started = 1'b0;
        credits    = DEPTH;
        m_ready    = 1'b1;
        m_acc      = 1'b0;
        m_chan     = '0;
        m_cred_out = 1'b0;
        m_valid    = 1'b0;
        m_ct       = '0;
        m_sx       = 0;
        m_sy       = 0;
    endtask

    // Predict the outputs seen after the coming clock edge
    task automatic model_edge(bit have, rx_item_t it);
        int avail;
        bit sent;
        avail = credits + int'(bus.credit_in_din);
        sent  = 1'b0;
        m_acc = 1'b0;
        if (bus.job_valid_din && m_ready) begin
            tx_q.push_back(hdr(int'(bus.dest_x_din), int'(bus.dest_y_din), 0, 0));
            tx_q.push_back(bus.plaintext_din[63:32]);
            tx_q.push_back(bus.plaintext_din[31:0]);
            tx_q.push_back(bus.key_din[63:32]);
            tx_q.push_back(bus.key_din[31:0]);
            tx_started = 1'b0;
            m_acc      = 1'b1;
        end
        m_chan = '0;
        if (tx_q.size() > 0 && (tx_started || avail >= NEED)) begin
            m_chan     = tx_q.pop_front();
            tx_started = 1'b1;
            sent       = 1'b1;
        end
        m_ready = (tx_q.size() == 0);
        credits = avail - int'(sent);
        if (credits > DEPTH) credits = DEPTH;

        m_cred_out = have && (it.flit != 32'h0 || it.body);
        m_valid    = 1'b0;
        if (have && it.last) begin
            m_valid = 1'b1;
            m_ct    = it.ct;
            m_sx    = it.sx;
            m_sy    = it.sy;
        end
    endtask

    task automatic check_outputs();
        check_eq("channel",      64'(bus.channel_dout),      64'(m_chan));
        check_eq("job_ready",    64'(bus.job_ready_dout),    64'(m_ready));
        check_eq("credit_out",   64'(bus.credit_out_dout),   64'(m_cred_out));
        check_eq("result_valid", 64'(bus.result_valid_dout), 64'(m_valid));
        check_eq("ciphertext",   bus.ciphertext_dout,        m_ct);
        check_eq("src_x",        64'(bus.result_src_x_dout), 64'(m_sx));
        check_eq("src_y",        64'(bus.result_src_y_dout), 64'(m_sy));
    endtask

    // One clock: present the next planned rx flit, advance the model, check after the edge
    task automatic cycle();
        rx_item_t it;
        bit       have;
        have = (rx_q.size() > 0);
        if (have) it = rx_q.pop_front();
        else      it = '{flit: 32'h0, body: 1'b0, last: 1'b0, ct: 64'h0, sx: 0, sy: 0};
        bus.channel_din = have ? it.flit : 32'h0;
        model_edge(have, it);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        bus.credit_in_din = 1'b0;
    endtask

    task automatic push_result(int sx, int sy, logic [63:0] c);
        rx_q.push_back('{flit: hdr(0, 0, sx, sy), body: 1'b1, last: 1'b0, ct: 64'h0, sx: 0, sy: 0});
        rx_q.push_back('{flit: c[63:32], body: 1'b1, last: 1'b0, ct: 64'h0, sx: 0, sy: 0});
        rx_q.push_back('{flit: c[31:0], body: 1'b1, last: 1'b1, ct: c, sx: sx, sy: sy});
    endtask

    task automatic push_garbage();
        logic [31:0] g;
        g = 32'($urandom_range(1, 32'h7FFF_FFFF));
        rx_q.push_back('{flit: g, body: 1'b0, last: 1'b0, ct: 64'h0, sx: 0, sy: 0});
    endtask

    task automatic offer_job(int dx, int dy, logic [63:0] p, logic [63:0] k);
        bit done;
        done              = 1'b0;
        bus.dest_x_din    = 4'(dx);
        bus.dest_y_din    = 4'(dy);
        bus.plaintext_din = p;
        bus.key_din       = k;
        bus.job_valid_din = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            done = m_acc;
        end
        bus.job_valid_din = 1'b0;
        check_eq("job_accepted", 64'(done), 64'd1);
    endtask

    task automatic give_credits(int n);
        for (int i = 0; i < n; i++) begin
            bus.credit_in_din = 1'b1;
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset             = 1'b1;
        bus.job_valid_din = 1'b0;
        bus.dest_x_din    = '0;
        bus.dest_y_din    = '0;
        bus.plaintext_din = '0;
        bus.key_din       = '0;
        bus.credit_in_din = 1'b0;
        bus.channel_din   = '0;
        basic_exp = '{32'h8000_2200, 32'h0123_4567, 32'h89AB_CDEF, 32'h1334_5779, 32'h9BBC_DFF1};
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Basic job to (2,2); header at k+1, ready returns in k+5
        offer_job(2, 2, 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1);
        check_eq("basic_flit0", 64'(bus.channel_dout), 64'(basic_exp[0]));
        check_eq("basic_ready0", 64'(bus.job_ready_dout), 64'd0);
        for (int i = 1; i < 5; i++) begin
            cycle();
            check_eq("basic_flit", 64'(bus.channel_dout), 64'(basic_exp[i]));
            check_eq("basic_ready", 64'(bus.job_ready_dout), 64'(i == 4));
        end

        // Credit stall: no credits left, header waits for the 5th returned credit
        pt  = {$urandom, $urandom};
        key = {$urandom, $urandom};
        offer_job(4, 1, pt, key);
        check_eq("stall_after_accept", 64'(bus.channel_dout), 64'd0);
        repeat (3) cycle();
        for (int p = 0; p < 5; p++) begin
            bus.credit_in_din = 1'b1;
            cycle();
            if (p < 4) check_eq("stall_idle", 64'(bus.channel_dout), 64'd0);
            else       check_eq("stall_header", 64'(bus.channel_dout), 64'(hdr(4, 1, 0, 0)));
        end
        // Credit returned alongside each remaining flit, then surplus credits to saturate
        give_credits(4);
        give_credits(3);
        offer_job(5, 6, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (4) cycle();
        offer_job(7, 8, {$urandom, $urandom}, {$urandom, $urandom});
        for (int p = 0; p < 4; p++) begin
            bus.credit_in_din = 1'b1;
            cycle();
            check_eq("sat_stall", 64'(bus.channel_dout), 64'd0);
        end
        give_credits(1);
        check_eq("sat_header", 64'(bus.channel_dout), 64'(hdr(7, 8, 0, 0)));
        repeat (4) cycle();

        // Result receive from node (1,3)
        push_result(1, 3, 64'h85E8_1354_0F0A_B405);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("rx_credit", 64'(bus.credit_out_dout), 64'd1);
        end
        check_eq("rx_valid", 64'(bus.result_valid_dout), 64'd1);
        check_eq("rx_ct", bus.ciphertext_dout, 64'h85E8_1354_0F0A_B405);
        check_eq("rx_src", 64'({bus.result_src_x_dout, bus.result_src_y_dout}), 64'h13);
        cycle();
        check_eq("rx_valid_drop", 64'(bus.result_valid_dout), 64'd0);

        // Full duplex: job out while a result comes in
        give_credits(5);
        ct = {$urandom, $urandom};
        push_result(2, 0, ct);
        offer_job(3, 3, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (6) cycle();
        check_eq("duplex_ct", bus.ciphertext_dout, ct);

        // Reset while flit 2 is on the channel
        give_credits(5);
        pt = {$urandom, $urandom};
        offer_job(9, 10, pt, {$urandom, $urandom});
        cycle();
        cycle();
        check_eq("pre_reset_flit2", 64'(bus.channel_dout), 64'(pt[31:0]));
        reset = 1'b1;
        #1;
        check_eq("reset_channel", 64'(bus.channel_dout), 64'd0);
        check_eq("reset_ready", 64'(bus.job_ready_dout), 64'd1);
        model_reset();
        bus.channel_din = '0;
        @(negedge clk);
        reset = 1'b0;
        offer_job(1, 2, {$urandom, $urandom}, {$urandom, $urandom});
        check_eq("post_reset_header", 64'(bus.channel_dout), 64'(hdr(1, 2, 0, 0)));
        repeat (4) cycle();

        // Randomized traffic in both directions
        for (int i = 0; i < 400; i++) begin
            if (!bus.job_valid_din && $urandom_range(0, 3) == 0) begin
                bus.dest_x_din    = 4'($urandom_range(0, 15));
                bus.dest_y_din    = 4'($urandom_range(0, 15));
                bus.plaintext_din = {$urandom, $urandom};
                bus.key_din       = {$urandom, $urandom};
                bus.job_valid_din = 1'b1;
            end
            bus.credit_in_din = 1'($urandom_range(0, 1));
            if (rx_q.size() == 0) begin
                case ($urandom_range(0, 5))
                    0, 1: push_result(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                      {$urandom, $urandom});
                    2:    push_garbage();
                    default: ;
                endcase
            end
            cycle();
            if (m_acc) bus.job_valid_din = 1'b0;
        end
        bus.job_valid_din = 1'b0;
        give_credits(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
